// File: rtl/bank_addr_map_pipe_pkg.sv
// Shared definitions for the bank address mapping pipeline.
//   mode_e        : per-beat mapping selector carried alongside each beat
//   DEF_*         : default geometry used by the interface and the top level
package bank_addr_map_pipe_pkg;

    typedef enum logic {
        MODE_KYBER     = 1'b0,  // digit-sum bank mapping
        MODE_DILITHIUM = 1'b1   // paired-parity bank mapping
    } mode_e;

    localparam int DEF_IDX_W  = 8;
    localparam int DEF_BANK_W = 2;
    localparam int DEF_CNT_W  = 16;

endpackage

// File: rtl/bank_addr_map_pipe_if.sv
// Bus bundle for bank_addr_map_pipe.
//   master : upstream/downstream side (drives beats in, accepts beats out)
//   slave  : the mapping pipeline itself
// Input side : flush, in_valid/in_ready, in_mode, in_idx (lane l at [l*IDX_W +: IDX_W])
// Output side: out_valid/out_ready, out_addr, out_bank, out_conflict,
//              conflict_cnt, conflict_sticky
interface bank_addr_map_pipe_if
    import bank_addr_map_pipe_pkg::*;
#(
    parameter int IDX_W  = DEF_IDX_W,
    parameter int BANK_W = DEF_BANK_W,
    parameter int CNT_W  = DEF_CNT_W
);
    localparam int NUM_LANES = 1 << BANK_W;

    logic                            flush;
    logic                            in_valid;
    logic                            in_ready;
    logic                            in_mode;
    logic [NUM_LANES*IDX_W-1:0]      in_idx;
    logic                            out_valid;
    logic                            out_ready;
    logic [NUM_LANES*(IDX_W-1)-1:0]  out_addr;
    logic [NUM_LANES*BANK_W-1:0]     out_bank;
    logic                            out_conflict;
    logic [CNT_W-1:0]                conflict_cnt;
    logic                            conflict_sticky;

    modport master (
        output flush, in_valid, in_mode, in_idx, out_ready,
        input  in_ready, out_valid, out_addr, out_bank, out_conflict,
               conflict_cnt, conflict_sticky
    );

    modport slave (
        input  flush, in_valid, in_mode, in_idx, out_ready,
        output in_ready, out_valid, out_addr, out_bank, out_conflict,
               conflict_cnt, conflict_sticky
    );

endinterface

// File: rtl/bank_addr_map_pipe_lane.sv
// bank_map_lane: purely combinational index-to-bank mapping for one lane.
//   idx      : this lane's coefficient index
//   pair_idx : index of the even lane of this lane's pair (lane & ~1)
//   mode     : MODE_KYBER or MODE_DILITHIUM
//   addr     : row address inside the selected bank
//   bank     : selected bank number
module bank_map_lane
    import bank_addr_map_pipe_pkg::*;
#(
    parameter int IDX_W  = DEF_IDX_W,
    parameter int BANK_W = DEF_BANK_W,
    parameter int LANE   = 0
) (
    input  logic [IDX_W-1:0]  idx,
    input  logic [IDX_W-1:0]  pair_idx,
    input  logic              mode,
    output logic [IDX_W-2:0]  addr,
    output logic [BANK_W-1:0] bank
);
    localparam int   ADDR_W   = IDX_W - 1;
    // Number of BANK_W-bit digits, rounding up so a short top digit is included.
    localparam int   NDIG     = (IDX_W + BANK_W - 1) / BANK_W;
    localparam logic LANE_ODD = ((LANE % 2) == 1);

    logic [NDIG*BANK_W-1:0] idx_pad;
    logic [BANK_W-1:0]      digit_sum;
    logic [ADDR_W-1:0]      addr_kyber;
    logic [ADDR_W-1:0]      addr_dil;
    logic [BANK_W-1:0]      bank_dil;
    logic                   pair_parity;

    // Zero-extend so the top partial digit reads as a full digit.
    assign idx_pad = (NDIG*BANK_W)'(idx);

    // The sum is held in BANK_W bits, so wrap-around gives mod NUM_BANKS for free.
    always_comb begin
        digit_sum = '0;
        for (int d = 0; d < NDIG; d++) begin
            digit_sum = digit_sum + idx_pad[d*BANK_W +: BANK_W];
        end
    end

    assign addr_kyber  = ADDR_W'(idx >> BANK_W);
    assign addr_dil    = idx[IDX_W-1:1];
    // Both lanes of a pair share the parity of the even lane's index, and the
    // lane's own low bit separates them, so a pair never collides.
    assign pair_parity = ^pair_idx;
    assign bank_dil    = BANK_W'({LANE_ODD, pair_parity});

    assign addr = (mode == MODE_DILITHIUM) ? addr_dil : addr_kyber;
    assign bank = (mode == MODE_DILITHIUM) ? bank_dil : digit_sum;

endmodule

// File: rtl/bank_addr_map_pipe.sv
// bank_addr_map_pipe: two-stage valid/ready pipeline mapping NUM_LANES
// coefficient indices per beat to (bank, address) pairs and flagging beats
// whose lanes collide on a bank.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset (beats in flight are lost)
//   bus  : bank_addr_map_pipe_if slave modport (handshakes, flush, results,
//          saturating conflict counter and sticky conflict flag)
// Stage S1 holds the mapped lanes; S2 holds them plus the conflict flag and
// drives the outputs. Latency 2 cycles, 1 beat/cycle without back-pressure.
module bank_addr_map_pipe
    import bank_addr_map_pipe_pkg::*;
#(
    parameter int IDX_W  = DEF_IDX_W,
    parameter int BANK_W = DEF_BANK_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input logic               clk,
    input logic               rst,
    bank_addr_map_pipe_if.slave bus
);
    localparam int NUM_LANES = 1 << BANK_W;
    localparam int ADDR_W    = IDX_W - 1;

    // The paired-parity mapping only produces a 2-bit bank number.
    generate
        if (BANK_W != 2) begin : g_bank_w_check
            $error("bank_addr_map_pipe: paired-parity mode needs BANK_W == 2");
        end
    endgenerate

    logic [NUM_LANES*ADDR_W-1:0] lane_addr;
    logic [NUM_LANES*BANK_W-1:0] lane_bank;

    generate
        for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            bank_map_lane #(
                .IDX_W  (IDX_W),
                .BANK_W (BANK_W),
                .LANE   (gi)
            ) u_lane (
                .idx      (bus.in_idx[gi*IDX_W +: IDX_W]),
                .pair_idx (bus.in_idx[(gi - (gi % 2))*IDX_W +: IDX_W]),
                .mode     (bus.in_mode),
                .addr     (lane_addr[gi*ADDR_W +: ADDR_W]),
                .bank     (lane_bank[gi*BANK_W +: BANK_W])
            );
        end
    endgenerate

    logic                        s1_valid_reg;
    logic [NUM_LANES*ADDR_W-1:0] s1_addr_reg;
    logic [NUM_LANES*BANK_W-1:0] s1_bank_reg;
    logic                        s1_conflict;

    logic                        s2_valid_reg;
    logic [NUM_LANES*ADDR_W-1:0] s2_addr_reg;
    logic [NUM_LANES*BANK_W-1:0] s2_bank_reg;
    logic                        s2_conflict_reg;

    logic [CNT_W-1:0]            cnt_reg;
    logic                        sticky_reg;

    logic s2_adv;
    logic s1_adv;
    logic in_fire;
    logic out_fire;

    // Ready ripples back combinationally so a full pipe keeps streaming.
    assign s2_adv       = !s2_valid_reg || bus.out_ready;
    assign s1_adv       = !s1_valid_reg || s2_adv;
    assign bus.in_ready = s1_adv && !bus.flush && !rst;
    assign in_fire      = bus.in_valid && bus.in_ready;
    assign out_fire     = s2_valid_reg && bus.out_ready;

    // Pairwise compare of every lane's bank against every later lane.
    always_comb begin
        s1_conflict = 1'b0;
        for (int i = 0; i < NUM_LANES; i++) begin
            for (int j = i + 1; j < NUM_LANES; j++) begin
                if (s1_bank_reg[i*BANK_W +: BANK_W] == s1_bank_reg[j*BANK_W +: BANK_W]) begin
                    s1_conflict = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_reg <= 1'b0;
            s1_addr_reg  <= '0;
            s1_bank_reg  <= '0;
        end else if (bus.flush) begin
            s1_valid_reg <= 1'b0;
        end else if (s1_adv) begin
            s1_valid_reg <= in_fire;
            if (in_fire) begin
                s1_addr_reg <= lane_addr;
                s1_bank_reg <= lane_bank;
            end
        end
    end

    // Data only moves on advance, which keeps the outputs frozen under stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid_reg    <= 1'b0;
            s2_addr_reg     <= '0;
            s2_bank_reg     <= '0;
            s2_conflict_reg <= 1'b0;
        end else if (bus.flush) begin
            s2_valid_reg <= 1'b0;
        end else if (s2_adv) begin
            s2_valid_reg <= s1_valid_reg;
            if (s1_valid_reg) begin
                s2_addr_reg     <= s1_addr_reg;
                s2_bank_reg     <= s1_bank_reg;
                s2_conflict_reg <= s1_conflict;
            end
        end
    end

    // Only delivered beats are counted; flush leaves the statistics alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg    <= '0;
            sticky_reg <= 1'b0;
        end else if (out_fire && s2_conflict_reg) begin
            sticky_reg <= 1'b1;
            if (cnt_reg != {CNT_W{1'b1}}) begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    assign bus.out_valid       = s2_valid_reg;
    assign bus.out_addr        = s2_addr_reg;
    assign bus.out_bank        = s2_bank_reg;
    assign bus.out_conflict    = s2_conflict_reg;
    assign bus.conflict_cnt    = cnt_reg;
    assign bus.conflict_sticky = sticky_reg;

endmodule

// File: tb/tb_bank_addr_map_pipe.sv
// Directed bench for bank_addr_map_pipe: a default-geometry instance for
// mapping/stall/flush checks and a CNT_W=2 instance for counter saturation.
module tb_bank_addr_map_pipe;
    import bank_addr_map_pipe_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bank_addr_map_pipe_if #(.IDX_W(8), .BANK_W(2), .CNT_W(16)) bus ();
    bank_addr_map_pipe_if #(.IDX_W(8), .BANK_W(2), .CNT_W(2))  bus2 ();

    bank_addr_map_pipe #(.IDX_W(8), .BANK_W(2), .CNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    bank_addr_map_pipe #(.IDX_W(8), .BANK_W(2), .CNT_W(2)) dut_sat (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    int vectors = 0;
    int errors  = 0;

    // Parity of popcount(k) for k = 0..9, worked out by hand.
    int p_tab [10] = '{0, 1, 1, 0, 1, 0, 0, 1, 1, 0};

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] idx4(input int a, input int b, input int c, input int d);
        return {8'(d), 8'(c), 8'(b), 8'(a)};
    endfunction

    function automatic logic [7:0] bank4(input int a, input int b, input int c, input int d);
        return {2'(d), 2'(c), 2'(b), 2'(a)};
    endfunction

    function automatic logic [27:0] addr4(input int a, input int b, input int c, input int d);
        return {7'(d), 7'(c), 7'(b), 7'(a)};
    endfunction

    task automatic drive(input logic v, input logic m, input logic [31:0] idx);
        bus.in_valid = v;
        bus.in_mode  = m;
        bus.in_idx   = idx;
    endtask

    task automatic drive2(input logic v, input logic m, input logic [31:0] idx);
        bus2.in_valid = v;
        bus2.in_mode  = m;
        bus2.in_idx   = idx;
    endtask

    task automatic expect_beat(input string tag, input logic [7:0] bank,
                               input logic [27:0] addr, input logic conf);
        check({tag, "_valid"},    bus.out_valid,    64'd1);
        check({tag, "_bank"},     bus.out_bank,     bank);
        check({tag, "_addr"},     bus.out_addr,     addr);
        check({tag, "_conflict"}, bus.out_conflict, conf);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_valid"},    bus.out_valid,       0);
        check({tag, "_addr"},     bus.out_addr,        0);
        check({tag, "_bank"},     bus.out_bank,        0);
        check({tag, "_conflict"}, bus.out_conflict,    0);
        check({tag, "_cnt"},      bus.conflict_cnt,    0);
        check({tag, "_sticky"},   bus.conflict_sticky, 0);
        check({tag, "_in_ready"}, bus.in_ready,        0);
        check({tag, "_sat_valid"},  bus2.out_valid,       0);
        check({tag, "_sat_cnt"},    bus2.conflict_cnt,    0);
        check({tag, "_sat_sticky"}, bus2.conflict_sticky, 0);
    endtask

    initial begin
        int tx;
        int rx;
        int p;

        rst = 1'b1;
        bus.flush = 1'b0;  bus.out_ready = 1'b1;  drive(0, 0, '0);
        bus2.flush = 1'b0; bus2.out_ready = 1'b1; drive2(0, 0, '0);
        tick();
        tick();
        check_zero("reset");
        rst = 1'b0;
        tick();

        // Kyber digit-sum mapping, no conflict, 2-cycle latency.
        drive(1, MODE_KYBER, idx4(4, 5, 6, 7));
        #1;
        check("k4567_in_ready", bus.in_ready, 1);
        tick();
        drive(0, 0, '0);
        check("k4567_lat1", bus.out_valid, 0);
        tick();
        expect_beat("k4567", bank4(1, 2, 3, 0), addr4(1, 1, 1, 1), 1'b0);
        tick();
        check("k4567_drained", bus.out_valid, 0);

        // Kyber mapping with a bank conflict; counter and sticky follow delivery.
        drive(1, MODE_KYBER, idx4(0, 5, 2, 3));
        tick();
        drive(0, 0, '0);
        tick();
        expect_beat("k0523", bank4(0, 2, 2, 3), addr4(0, 1, 0, 0), 1'b1);
        check("k0523_cnt_before", bus.conflict_cnt, 0);
        tick();
        check("k0523_cnt", bus.conflict_cnt, 1);
        check("k0523_sticky", bus.conflict_sticky, 1);

        // Mixed modes back to back.
        drive(1, MODE_DILITHIUM, idx4(0, 0, 1, 1));
        tick();
        drive(1, MODE_KYBER, idx4(4, 5, 6, 7));
        tick();
        expect_beat("d0011", bank4(0, 2, 1, 3), addr4(0, 0, 0, 0), 1'b0);
        drive(1, MODE_DILITHIUM, idx4(6, 6, 7, 7));
        tick();
        expect_beat("mix_k4567", bank4(1, 2, 3, 0), addr4(1, 1, 1, 1), 1'b0);
        drive(0, 0, '0);
        tick();
        expect_beat("d6677", bank4(0, 2, 1, 3), addr4(3, 3, 3, 3), 1'b0);
        tick();
        check("mix_drained", bus.out_valid, 0);

        // Ten-beat stream with a 3-cycle downstream stall.
        // Beat k: idx {2k,2k,2k+1,2k+1} -> addr k, banks {p,2+p,1-p,3-p}.
        tx = 0;
        rx = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (tx < 10) drive(1, MODE_DILITHIUM, idx4(2*tx, 2*tx, 2*tx + 1, 2*tx + 1));
            else         drive(0, 0, '0);
            bus.out_ready = !(cyc >= 4 && cyc < 7);
            #1;
            if (cyc == 5) begin
                check("stall_in_ready", bus.in_ready, 0);
                check("stall_out_valid", bus.out_valid, 1);
            end
            if (bus.out_valid) begin
                if (rx < 10) begin
                    p = p_tab[rx];
                    expect_beat($sformatf("stream%0d", rx), bank4(p, 2 + p, 1 - p, 3 - p),
                                addr4(rx, rx, rx, rx), 1'b0);
                end else begin
                    check("stream_extra_beat", bus.out_valid, 0);
                end
                if (bus.out_ready) rx++;
            end
            if (bus.in_valid && bus.in_ready) tx++;
            tick();
        end
        check("stream_tx_count", tx, 10);
        check("stream_rx_count", rx, 10);
        bus.out_ready = 1'b1;

        // Flush with two beats in flight; the beat offered during flush is dropped.
        drive(1, MODE_KYBER, idx4(4, 5, 6, 7));
        tick();
        drive(1, MODE_KYBER, idx4(0, 5, 2, 3));
        tick();
        check("flush_pre_valid", bus.out_valid, 1);
        bus.flush = 1'b1;
        drive(1, MODE_DILITHIUM, idx4(6, 6, 7, 7));
        #1;
        check("flush_in_ready", bus.in_ready, 0);
        tick();
        bus.flush = 1'b0;
        drive(0, 0, '0);
        check("flush_out_valid", bus.out_valid, 0);
        tick();
        check("flush_drained", bus.out_valid, 0);
        drive(1, MODE_DILITHIUM, idx4(6, 6, 7, 7));
        #1;
        check("post_flush_in_ready", bus.in_ready, 1);
        tick();
        drive(0, 0, '0);
        check("post_flush_lat1", bus.out_valid, 0);
        tick();
        expect_beat("post_flush", bank4(0, 2, 1, 3), addr4(3, 3, 3, 3), 1'b0);
        tick();
        check("flush_cnt_kept", bus.conflict_cnt, 1);
        check("flush_sticky_kept", bus.conflict_sticky, 1);

        // Counter saturation on the CNT_W=2 instance.
        for (int k = 0; k < 5; k++) begin
            drive2(1, MODE_KYBER, idx4(0, 5, 2, 3));
            tick();
        end
        drive2(0, 0, '0);
        tick();
        tick();
        tick();
        check("sat_cnt", bus2.conflict_cnt, 3);
        check("sat_sticky", bus2.conflict_sticky, 1);

        // Reset mid-stream wins over everything; in-flight beats are lost.
        drive(1, MODE_KYBER, idx4(4, 5, 6, 7));
        drive2(1, MODE_KYBER, idx4(0, 5, 2, 3));
        tick();
        tick();
        check("rst_pre_valid", bus.out_valid, 1);
        check("rst_pre_sat_valid", bus2.out_valid, 1);
        rst = 1'b1;
        tick();
        check_zero("rst_mid");
        rst = 1'b0;
        drive(0, 0, '0);
        drive2(0, 0, '0);
        tick();
        check("rst_lost1", bus.out_valid, 0);
        tick();
        check("rst_lost2", bus.out_valid, 0);
        check("rst_lost2_sat", bus2.out_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/bank_addr_map_pipe.md
BANK_ADDR_MAP_PIPE -- requirements
Module: bank_addr_map_pipe

Interface
REQ-001 SHALL have parameter IDX_W, default 8, meaning coefficient index width per lane.
REQ-002 SHALL have parameter BANK_W, default 2, meaning bank-index width; NUM_LANES = NUM_BANKS = 2^BANK_W.
REQ-003 SHALL have parameter CNT_W, default 16, meaning conflict-counter width.
REQ-004 SHALL have ports as follows, one per line:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  reset; synchronous, active-high.
- flush  in  1  drops all in-flight beats.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid && in_ready.
- in_mode  in  1  0 = Kyber digit-sum mapping; 1 = Dilithium paired-parity mapping; carried with the beat.
- in_idx  in  NUM_LANES*IDX_W  lane l index at [l*IDX_W +: IDX_W].
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts when out_valid && out_ready.
- out_addr  out  NUM_LANES*(IDX_W-1)  per-lane bank address.
- out_bank  out  NUM_LANES*BANK_W  per-lane bank number.
- out_conflict  out  1  two or more lanes of this beat map to the same bank.
- conflict_cnt  out  CNT_W  saturating count of conflicting beats delivered.
- conflict_sticky  out  1  set on first delivered conflicting beat; cleared only by rst.

Function
REQ-005 Mode 0: addr = idx >> BANK_W, zero-extended to IDX_W-1; bank = (sum of all BANK_W-bit digits of idx) mod NUM_BANKS, with the top partial digit zero-extended.
REQ-006 Mode 1: addr = idx[IDX_W-1:1]; for lane l, p = XOR of all bits of idx of lane (l with bit 0 cleared); bank = {l[0], p}.
REQ-007 Mode 1 SHALL be legal only when BANK_W == 2; any other BANK_W SHALL be an elaboration error.
REQ-008 Pipeline: stage S1 registers addr, bank and mode; stage S2 registers the S1 results plus out_conflict, which is the pairwise bank compare across all lanes.
REQ-009 Latency SHALL be 2 cycles from acceptance to out_valid when there is no back-pressure; throughput SHALL be 1 beat/cycle.
REQ-010 Each stage SHALL advance when it is empty or the next stage advances; in_ready = !S1_valid || S1_advances (combinational from out_ready; no bubble).
REQ-011 While out_valid && !out_ready, all out_* signals SHALL hold stable.
REQ-012 Beats SHALL never be dropped or duplicated except by flush or rst.
REQ-013 conflict_cnt SHALL increment by 1 on each handshake with out_conflict=1 and SHALL saturate at 2^CNT_W-1.
REQ-014 flush SHALL clear S1_valid and S2_valid at the next edge; in_ready SHALL be 0 in the flush cycle; counter and sticky SHALL be unaffected.
REQ-015 A beat presented together with flush SHALL be discarded.
REQ-016 Mixed-mode beats back-to-back SHALL each be mapped by their own in_mode.

Reset
REQ-017 On rst: S1_valid=0, S2_valid=0, out_valid=0, out_addr=0, out_bank=0, out_conflict=0, conflict_cnt=0, conflict_sticky=0.
REQ-018 rst SHALL take priority over flush and handshakes; an in-flight beat SHALL be lost; in_ready SHALL be 0 during rst.

Structure
REQ-019 A shared package SHALL hold the mode encodings (MODE_KYBER=0, MODE_DILITHIUM=1) and the default IDX_W/BANK_W constants.
REQ-020 One sub-module, bank_map_lane, SHALL perform the per-lane combinational mapping; it is instantiated NUM_LANES times.
REQ-021 Pipeline registers SHALL reuse the team DFF cell where no enable is needed.

Verification
REQ-022 Mode 0, idx {4,5,6,7} -> after 2 cycles banks {1,2,3,0}, addr {1,1,1,1}, conflict 0.
REQ-023 Mode 0, idx {0,5,2,3} -> banks {0,2,2,3}, conflict 1, conflict_cnt 1, sticky 1.
REQ-024 Mode 1, lane idx {0,0,1,1} -> banks {0,2,1,3}, addr {0,0,0,0}, conflict 0; idx {6,6,7,7} -> banks {0,2,1,3}, addr {3,3,3,3}.
REQ-025 Ten back-to-back beats with out_ready held low for 3 cycles mid-stream -> outputs stable while stalled, all ten delivered in order, no drops.
REQ-026 flush asserted with 2 beats in flight -> out_valid=0 the next cycle; subsequent beat appears 2 cycles after acceptance.
REQ-027 CNT_W=2, five conflicting beats -> conflict_cnt saturates at 3; rst mid-stream -> all outputs zero on the next cycle.
